random_word_collector: RTL and testbench

Consumer end of the randomness-source handshake. It accepts RATE-bit chunks from a producer such as the spongent-whitened entropy source, using the producer's valid/received protocol. It assembles the chunks into WORD-bit words, buffers them in a small FIFO, and presents them on a ready/valid port. A repetition-count health test runs on the chunk stream, and on failure the block stops and discards all buffered randomness.

---
 rtl/random_word_collector_pkg.sv | 9 +
 rtl/random_word_collector_word_fifo.sv | 76 +++++++
 rtl/random_word_collector.sv | 112 +++++++++++
 tb/tb_random_word_collector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_word_collector_pkg.sv
// Shared helpers for the random word collector and its word FIFO.
package random_word_collector_pkg;

  // Width of a counter or index that must address n distinct values (never zero).
  function automatic int unsigned width_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/random_word_collector_word_fifo.sv
// Small synchronous FIFO with a registered head word and a single-cycle flush.
// The head register changes only on a pop or on a push into an empty FIFO,
// so the output holds its last value while the FIFO is empty.
module word_fifo
  import random_word_collector_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = width_for(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   next_rd;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Occupancy, guarded push/pop and the address of the word behind the head.
  always_comb begin
    count   = wr_ptr - rd_ptr;
    full    = (count == (PTR_W+1)'(DEPTH));
    empty   = (wr_ptr == rd_ptr);
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    next_rd = rd_ptr + (PTR_W+1)'(1);
  end

  // Storage array; holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PTR_W-1:0]] <= data;
    end
  end

  // Pointers and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= next_rd;
      end
      if (do_push && empty) begin
        head <= data;
      end else if (do_pop) begin
        if (count > (PTR_W+1)'(1)) begin
          head <= mem[next_rd[PTR_W-1:0]];
        end else if (do_push) begin
          head <= data;
        end
      end
    end
  end

endmodule

// File: rtl/random_word_collector.sv
// Consumer end of the randomness handshake: captures RATE-bit chunks with a
// valid/received protocol, packs them little-endian into WORD-bit words,
// buffers the words and runs a repetition-count health test on the chunks.
module random_word_collector
  import random_word_collector_pkg::*;
#(
  parameter int unsigned RATE         = 8,
  parameter int unsigned WORD         = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RATE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_received,
  output logic [WORD-1:0] word_data,
  output logic            word_valid,
  input  logic            word_ready,
  input  logic            health_clear,
  output logic            health_fail
);

  localparam int unsigned CHUNKS = WORD / RATE;
  localparam int unsigned CNT_W  = width_for(CHUNKS);
  localparam int unsigned RUN_W  = width_for(REPEAT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(REPEAT_LIMIT);

  logic [CNT_W-1:0] chunk_cnt;
  logic [WORD-1:0]  partial;
  logic [RATE-1:0]  prev_chunk;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic [WORD-1:0]  full_word;
  logic             last_chunk;
  logic             accept;
  logic             trip;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign word_valid = !fifo_empty;

  // Accept decision, repetition run update and the word formed by this chunk.
  // A run count of zero marks "no previous chunk" after reset or clear.
  always_comb begin
    last_chunk = (chunk_cnt == LAST_IDX);
    accept     = in_valid && !in_received && !health_fail && !health_clear &&
                 !(last_chunk && fifo_full);
    run_next   = (run_cnt != '0 && in_data == prev_chunk) ? run_cnt + RUN_W'(1) : RUN_W'(1);
    trip       = accept && (run_next == RUN_TRIP);
    full_word  = partial | (WORD'(in_data) << (chunk_cnt * RATE));
    push       = accept && last_chunk && !trip;
    pop        = word_valid && word_ready;
  end

  // Handshake pulse, assembly register, chunk counter and health state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_received <= 1'b0;
      health_fail <= 1'b0;
      chunk_cnt   <= '0;
      partial     <= '0;
      prev_chunk  <= '0;
      run_cnt     <= '0;
    end else begin
      in_received <= accept;
      if (health_clear) begin
        health_fail <= 1'b0;
        chunk_cnt   <= '0;
        partial     <= '0;
        prev_chunk  <= '0;
        run_cnt     <= '0;
      end else if (trip) begin
        // The failing chunk is acknowledged but never enters a word.
        health_fail <= 1'b1;
        chunk_cnt   <= '0;
        partial     <= '0;
        prev_chunk  <= in_data;
        run_cnt     <= '0;
      end else if (accept) begin
        prev_chunk <= in_data;
        run_cnt    <= run_next;
        if (last_chunk) begin
          chunk_cnt <= '0;
          partial   <= '0;
        end else begin
          chunk_cnt <= chunk_cnt + CNT_W'(1);
          partial   <= full_word;
        end
      end
    end
  end

  word_fifo #(
    .WIDTH (WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (trip),
    .push  (push),
    .data  (full_word),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (word_data)
  );

endmodule

// File: tb/tb_random_word_collector.sv
// Bench for random_word_collector: directed and randomized chunk streams
// against a chunk-list/word-queue reference model.
module tb_random_word_collector;

  localparam int RATE   = 8;
  localparam int WORD   = 32;
  localparam int DEPTH  = 4;
  localparam int LIMIT  = 4;
  localparam int CHUNKS = WORD / RATE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_received;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        health_clear = 1'b0;
  logic        health_fail;

  random_word_collector #(
    .RATE(RATE), .WORD(WORD), .FIFO_DEPTH(DEPTH), .REPEAT_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_received(in_received), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .health_clear(health_clear), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int pops = 0;
  logic prev_rcv = 1'b0;

  // Reference model: pending chunks of the current word, queue of complete
  // words the sink should see, and the current run of identical chunks.
  logic [7:0]  m_part[$];
  logic [31:0] m_q[$];
  int          m_run = 0;
  logic [7:0]  m_prev = '0;
  bit          m_fail = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_part.delete(); m_q.delete(); m_run = 0; m_prev = '0; m_fail = 1'b0;
  endtask

  task automatic m_clear();
    m_part.delete(); m_run = 0; m_prev = '0; m_fail = 1'b0;
  endtask

  function automatic bit m_blocked();
    return m_fail || (m_part.size() == CHUNKS - 1 && m_q.size() == DEPTH);
  endfunction

  task automatic m_take(input logic [7:0] d);
    logic [31:0] w;
    if (m_run > 0 && d == m_prev) m_run++;
    else m_run = 1;
    m_prev = d;
    if (m_run >= LIMIT) begin
      m_fail = 1'b1; m_run = 0; m_part.delete(); m_q.delete();
    end else begin
      m_part.push_back(d);
      if (m_part.size() == CHUNKS) begin
        w = '0;
        for (int i = 0; i < CHUNKS; i++) w[i*RATE +: RATE] = m_part[i];
        m_q.push_back(w);
        m_part.delete();
      end
    end
  endtask

  // Per-cycle output checks at the falling edge against the model.
  always @(negedge clk) begin
    if (in_received) pulses++;
    check("rcv_pulse_width", {31'b0, in_received && prev_rcv}, 32'd0);
    prev_rcv = in_received;
    check("health_fail", {31'b0, health_fail}, {31'b0, m_fail});
    check("word_valid", {31'b0, word_valid}, {31'b0, m_q.size() != 0});
    if (word_valid && m_q.size() != 0) check("word_data", word_data, m_q[0]);
    if (word_valid && word_ready) begin
      pops++;
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
  end

  // Offer one chunk and wait (bounded) for its acknowledgement.
  task automatic send(input logic [7:0] d, input int limit, output bit acked, output int waited);
    in_data = d; in_valid = 1'b1; acked = 1'b0; waited = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      waited++;
      if (in_received) begin acked = 1'b1; break; end
    end
    if (acked) m_take(d);
  endtask

  task automatic put(input logic [7:0] d);
    bit a; int w;
    send(d, 60, a, w);
    check("ack", {31'b0, a}, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_received"}, {31'b0, in_received}, 32'd0);
    check({tag, "_word_valid"}, {31'b0, word_valid}, 32'd0);
    check({tag, "_word_data"}, word_data, 32'd0);
    check({tag, "_health_fail"}, {31'b0, health_fail}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a; int w; int p0; logic [7:0] d;

    // Reset state
    cycles(2);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    cycles(1);

    // Basic assembly with the sink always ready
    p0 = pulses;
    put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    idle();
    check("basic_valid", {31'b0, word_valid}, 32'd1);
    check("basic_word", word_data, 32'h04030201);
    cycles(3);
    check("basic_pulses", pulses - p0, 4);

    // Handshake spacing: one capture every second cycle
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 60, a, w);
      check("spacing_ack", {31'b0, a}, 32'd1);
      check("spacing_cycles", w, (i == 0) ? 1 : 2);
    end
    idle();
    cycles(4);
    check("spacing_words", pops - p0, 2);

    // Backpressure: four words buffered, the completing chunk is held off
    word_ready = 1'b0;
    for (int i = 0; i <= 8'h12; i++) put(8'(i));
    send(8'h13, 20, a, w);
    check("bp_blocked", {31'b0, a}, {31'b0, !m_blocked()});
    check("bp_valid", {31'b0, word_valid}, 32'd1);
    check("bp_head", word_data, 32'h03020100);
    p0 = pops;
    word_ready = 1'b1;
    send(8'h13, 60, a, w);
    check("bp_release_ack", {31'b0, a}, 32'd1);
    idle();
    cycles(12);
    check("bp_pops", pops - p0, 5);
    check("bp_drained", {31'b0, word_valid}, 32'd0);

    // Health trip with two words buffered
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 127));
      if (d == m_prev) d = d ^ 8'h01;
      put(d);
    end
    idle();
    cycles(2);
    check("ht_buffered", {31'b0, word_valid}, 32'd1);
    p0 = pulses;
    put(8'hAA); put(8'hAA); put(8'hAA); put(8'hAA);
    idle();
    check("ht_fail", {31'b0, health_fail}, 32'd1);
    check("ht_flushed", {31'b0, word_valid}, 32'd0);
    cycles(2);
    check("ht_pulses", pulses - p0, 4);
    send(8'h5A, 10, a, w);
    check("ht_no_accept", {31'b0, a}, {31'b0, !m_blocked()});
    idle();
    cycles(1);
    health_clear = 1'b1;
    cycles(1);
    health_clear = 1'b0;
    m_clear();
    check("ht_cleared", {31'b0, health_fail}, 32'd0);
    word_ready = 1'b1;
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    idle();
    check("ht_after_word", word_data, 32'h44332211);
    cycles(3);

    // Clear wins over a chunk offered in the same cycle
    put(8'h77); put(8'h77); put(8'h77);
    cycles(1);
    in_data = 8'h77; in_valid = 1'b1; health_clear = 1'b1;
    cycles(1);
    in_valid = 1'b0; health_clear = 1'b0;
    m_clear();
    check("clr_no_capture", {31'b0, in_received}, 32'd0);
    check("clr_no_fail", {31'b0, health_fail}, 32'd0);
    cycles(1);

    // Repetition boundary: one short of the limit is fine
    put(8'h55); put(8'h55); put(8'h55); put(8'h56);
    idle();
    check("rep_no_fail", {31'b0, health_fail}, 32'd0);
    check("rep_word", word_data, 32'h56555555);
    cycles(3);

    // Asynchronous reset in the middle of a word
    put(8'h31); put(8'h32);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    m_reset();
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    put(8'hA0); put(8'hA1); put(8'hA2); put(8'hA3);
    idle();
    check("rst_word", word_data, 32'hA3A2A1A0);
    cycles(3);

    // Randomized stream with a randomly stalling sink
    for (int i = 0; i < 48; i++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      if (m_q.size() == DEPTH) word_ready = 1'b1;
      d = m_prev ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 4) == 0 && m_run < LIMIT - 1) d = m_prev;
      put(d);
    end
    idle();
    word_ready = 1'b1;
    cycles(20);
    check("rand_drained", {31'b0, word_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
